// File: rtl/metadata_queue_pkg.sv
// Shared types for the metadata capture queue.
// Contents:
//   mac_addr_t       - 48-bit MAC address
//   eth_metadata_t   - per-frame parse/classification result
//   meta_cap_state_e - capture FSM states (IDLE, IN_FRAME, CAPTURED)
//   META_W           - packed width of eth_metadata_t
// The queue descriptor (metadata + sequence number, plus a timestamp when
// METADATA_TIMESTAMP_EN is defined) depends on module parameters. It is
// therefore declared inside metadata_queue rather than here.
package metadata_queue_pkg;

  typedef logic [47:0] mac_addr_t;

  typedef struct packed {
    mac_addr_t   dest_mac;
    mac_addr_t   src_mac;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic [15:0] resolved_ethertype;
    logic [4:0]  l2_header_len;
    logic        is_ipv4;
    logic        is_ipv6;
    logic        is_arp;
    logic        is_unknown;
  } eth_metadata_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    CAPTURED = 2'd2
  } meta_cap_state_e;

  localparam int META_W = $bits(eth_metadata_t);

endpackage

// File: rtl/metadata_queue_fifo.sv
// meta_fifo: generic first-word-fall-through FIFO.
// The head entry is visible on o_rd_data whenever o_empty is low.
// Parameters:
//   WIDTH - entry width
//   DEPTH - number of entries (power of two, >= 2)
// Ports:
//   clk, rst_n    - clock, async active-low reset (clears pointers/level)
//   i_push        - write i_wr_data. Accepted when not full, or when full
//                   and popping in the same cycle.
//   i_wr_data     - entry to write
//   i_pop         - retire the head entry (ignored while empty)
//   o_rd_data     - head entry (undefined contents while empty)
//   o_full        - level == DEPTH
//   o_empty       - level == 0
//   o_level       - occupancy, 0..DEPTH
module meta_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  // When full, a simultaneous pop frees the head slot. The write pointer equals
  // the read pointer in that case, so the new entry lands in the slot that is
  // being retired.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage needs no reset. Entries are only observed while the level covers them.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/metadata_queue.sv
// metadata_queue: captures one eth_metadata_t per frame when classification
// resolves. Each capture is tagged with a sequence number. Descriptors are
// buffered in a DEPTH-entry FWFT FIFO and offered downstream over valid/ready.
// Captures that find the FIFO full are dropped. A drop pulses overflow and
// increments a saturating drop counter. Dropped captures still consume a
// sequence number, so consumers can see loss as gaps.
// Optional feature macro: METADATA_TIMESTAMP_EN
//   Adds a free-running TS_W counter. The counter is latched at frame_start,
//   stored per entry, and driven on m_timestamp. The port is absent otherwise.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   frame_start/frame_end       - first/last beat of a frame
//   proto_valid                 - classification resolved; field inputs valid
//   dest_mac .. is_unknown      - parsed fields
//   m_valid/m_ready             - head descriptor handshake
//   m_metadata/m_seq            - head descriptor (zero while empty)
//   m_timestamp                 - head frame_start time (macro only)
//   level                       - FIFO occupancy
//   drop_cnt                    - saturating count of dropped captures
//   overflow                    - one-cycle pulse per drop
module metadata_queue
  import metadata_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic                frame_end,
  input  logic                proto_valid,
  input  mac_addr_t           dest_mac,
  input  mac_addr_t           src_mac,
  input  logic                vlan_present,
  input  logic [11:0]         vlan_id,
  input  logic [15:0]         resolved_ethertype,
  input  logic [4:0]          l2_header_len,
  input  logic                is_ipv4,
  input  logic                is_ipv6,
  input  logic                is_arp,
  input  logic                is_unknown,
  output logic                m_valid,
  input  logic                m_ready,
  output eth_metadata_t       m_metadata,
  output logic [SEQ_W-1:0]    m_seq,
`ifdef METADATA_TIMESTAMP_EN
  output logic [TS_W-1:0]     m_timestamp,
`endif
  output logic [LW-1:0]       level,
  output logic [CNT_W-1:0]    drop_cnt,
  output logic                overflow
);

  typedef struct packed {
    eth_metadata_t    md;
    logic [SEQ_W-1:0] seq;
`ifdef METADATA_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
  } meta_desc_t;

  localparam int DESC_W = $bits(meta_desc_t);

  meta_cap_state_e   r_state;
  meta_cap_state_e   w_next_state;
  logic              w_capture;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [SEQ_W-1:0]  r_seq;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              r_overflow;
  meta_desc_t        w_push_desc;
  meta_desc_t        w_head;
  logic [DESC_W-1:0] w_rd_data;
  logic [LW-1:0]     w_level;

  // Capture state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // frame_start always opens a new frame.
  // If classification resolves on the same beat, that beat is captured and the
  // frame is already CAPTURED. This keeps the rule of one descriptor per frame.
  always_comb begin
    w_next_state = r_state;
    w_capture    = proto_valid && (frame_start || (r_state == IN_FRAME));
    if (frame_start) begin
      w_next_state = proto_valid ? CAPTURED : IN_FRAME;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = IDLE;
        end
        IN_FRAME: begin
          if (frame_end) begin
            w_next_state = IDLE;
          end else if (proto_valid) begin
            w_next_state = CAPTURED;
          end
        end
        CAPTURED: begin
          if (frame_end) begin
            w_next_state = IDLE;
          end
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

`ifdef METADATA_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_ctr;
  logic [TS_W-1:0] r_ts_frame;
  logic [TS_W-1:0] w_ts;

  // Free-running timestamp. It is latched on frame_start for the frame's descriptor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_ctr   <= '0;
      r_ts_frame <= '0;
    end else begin
      r_ts_ctr <= r_ts_ctr + TS_W'(1);
      if (frame_start) begin
        r_ts_frame <= r_ts_ctr;
      end
    end
  end

  assign w_ts = frame_start ? r_ts_ctr : r_ts_frame;
`endif

  // Assemble the descriptor from the live parser fields.
  always_comb begin
    w_push_desc                       = '0;
    w_push_desc.md.dest_mac           = dest_mac;
    w_push_desc.md.src_mac            = src_mac;
    w_push_desc.md.vlan_present       = vlan_present;
    w_push_desc.md.vlan_id            = vlan_id;
    w_push_desc.md.resolved_ethertype = resolved_ethertype;
    w_push_desc.md.l2_header_len      = l2_header_len;
    w_push_desc.md.is_ipv4            = is_ipv4;
    w_push_desc.md.is_ipv6            = is_ipv6;
    w_push_desc.md.is_arp             = is_arp;
    w_push_desc.md.is_unknown         = is_unknown;
    w_push_desc.seq                   = r_seq;
`ifdef METADATA_TIMESTAMP_EN
    w_push_desc.ts                    = w_ts;
`endif
  end

  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_pop  = m_valid && m_ready;
  assign w_push = w_capture && (!w_full || w_pop);
  assign w_drop = w_capture && !w_push;

  meta_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wr_data (w_push_desc),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  // Sequence counter advances on every capture, including dropped ones.
  // The drop counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_capture) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign w_head     = meta_desc_t'(w_rd_data);
  assign m_valid    = !w_empty;
  assign m_metadata = w_empty ? '0 : w_head.md;
  assign m_seq      = w_empty ? '0 : w_head.seq;
`ifdef METADATA_TIMESTAMP_EN
  assign m_timestamp = w_empty ? '0 : w_head.ts;
`endif
  assign level      = w_level;
  assign drop_cnt   = r_drop_cnt;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_metadata_queue.sv
// Directed bench for metadata_queue.
// Configuration: DEPTH=8, SEQ_W=4, CNT_W=2.
// The small widths make sequence wrap and drop-counter saturation reachable.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_metadata_queue;
  import metadata_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int SEQ_W = 4;
  localparam int CNT_W = 2;
  localparam int TS_W  = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             frame_start;
  logic             frame_end;
  logic             proto_valid;
  mac_addr_t        dest_mac;
  mac_addr_t        src_mac;
  logic             vlan_present;
  logic [11:0]      vlan_id;
  logic [15:0]      resolved_ethertype;
  logic [4:0]       l2_header_len;
  logic             is_ipv4;
  logic             is_ipv6;
  logic             is_arp;
  logic             is_unknown;
  logic             m_valid;
  logic             m_ready;
  eth_metadata_t    m_metadata;
  logic [SEQ_W-1:0] m_seq;
`ifdef METADATA_TIMESTAMP_EN
  logic [TS_W-1:0]  m_timestamp;
`endif
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] drop_cnt;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  metadata_queue #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W),
    .CNT_W (CNT_W),
    .TS_W  (TS_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .frame_start        (frame_start),
    .frame_end          (frame_end),
    .proto_valid        (proto_valid),
    .dest_mac           (dest_mac),
    .src_mac            (src_mac),
    .vlan_present       (vlan_present),
    .vlan_id            (vlan_id),
    .resolved_ethertype (resolved_ethertype),
    .l2_header_len      (l2_header_len),
    .is_ipv4            (is_ipv4),
    .is_ipv6            (is_ipv6),
    .is_arp             (is_arp),
    .is_unknown         (is_unknown),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_metadata         (m_metadata),
    .m_seq              (m_seq),
`ifdef METADATA_TIMESTAMP_EN
    .m_timestamp        (m_timestamp),
`endif
    .level              (level),
    .drop_cnt           (drop_cnt),
    .overflow           (overflow)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive control inputs, then advance one rising edge and settle 1 ns.
  task automatic applyStimulus(input logic fs, input logic fe, input logic pv,
                               input logic rdy);
    frame_start = fs;
    frame_end   = fe;
    proto_valid = pv;
    m_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic setMeta(input logic [15:0] et, input logic [3:0] flags);
    resolved_ethertype = et;
    {is_ipv4, is_ipv6, is_arp, is_unknown} = flags;
  endtask

  // A two-beat frame: frame_start, then proto_valid together with frame_end.
  task automatic runFrame(input logic rdy);
    applyStimulus(1'b1, 1'b0, 1'b0, rdy);
    applyStimulus(1'b0, 1'b1, 1'b1, rdy);
  endtask

  task automatic doReset();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    proto_valid = 1'b0;
    m_ready     = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int exp4 [8] = '{1, 2, 3, 4, 5, 6, 7, 10};
  int pulses;

  initial begin
    rst_n              = 1'b1;
    frame_start        = 1'b0;
    frame_end          = 1'b0;
    proto_valid        = 1'b0;
    m_ready            = 1'b0;
    dest_mac           = 48'h0011_2233_4455;
    src_mac            = 48'hA0B0_C0D0_E0F0;
    vlan_present       = 1'b0;
    vlan_id            = 12'h000;
    l2_header_len      = 5'd14;
    setMeta(16'h0000, 4'b0000);
    #1;
    doReset();

    // Reset state.
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_m_seq", 64'(m_seq), 64'd0);
    checkOutput("rst_md_nonzero", 64'(|m_metadata), 64'd0);

    // 1: IPv4 frame, proto_valid three edges after frame_start, consumer ready.
    $display("[TB] step 1: single IPv4 frame");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    setMeta(16'h0800, 4'b1000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t1_m_valid", 64'(m_valid), 64'd1);
    checkOutput("t1_m_seq", 64'(m_seq), 64'd0);
    checkOutput("t1_is_ipv4", 64'(m_metadata.is_ipv4), 64'd1);
    checkOutput("t1_ethertype", 64'(m_metadata.resolved_ethertype), 64'h0800);
    checkOutput("t1_dest_mac", 64'(m_metadata.dest_mac), 64'h0011_2233_4455);
    checkOutput("t1_level_1", 64'(level), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_level_0", 64'(level), 64'd0);
    checkOutput("t1_m_valid_0", 64'(m_valid), 64'd0);

    // 2: extra proto_valid within a frame, and in IDLE, are ignored.
    $display("[TB] step 2: repeated proto_valid ignored");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    setMeta(16'h86DD, 4'b0100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_m_seq", 64'(m_seq), 64'd1);
    checkOutput("t2_is_ipv6", 64'(m_metadata.is_ipv6), 64'd1);
    checkOutput("t2_level_a", 64'(level), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_level_b", 64'(level), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_level_c", 64'(level), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_idle_level", 64'(level), 64'd1);
    checkOutput("t2_head_seq", 64'(m_seq), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_drained", 64'(level), 64'd0);
    runFrame(1'b0);
    checkOutput("t2_next_seq", 64'(m_seq), 64'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: ten frames with no consumer, so the last two are dropped.
    $display("[TB] step 3: overflow");
    doReset();
    setMeta(16'h0806, 4'b0010);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      runFrame(1'b0);
      checkOutput($sformatf("t3_ovf_%0d", i), 64'(overflow), 64'(i >= 8));
      if (overflow === 1'b1) pulses++;
    end
    checkOutput("t3_level", 64'(level), 64'd8);
    checkOutput("t3_drop_cnt", 64'(drop_cnt), 64'd2);
    checkOutput("t3_pulses", 64'(pulses), 64'd2);
    checkOutput("t3_head_seq", 64'(m_seq), 64'd0);
    checkOutput("t3_is_arp", 64'(m_metadata.is_arp), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t3_ovf_clear", 64'(overflow), 64'd0);

    // 4: capture into a full FIFO while the head pops (seq 10 replaces seq 0).
    $display("[TB] step 4: full passthrough");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_level", 64'(level), 64'd8);
    checkOutput("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    checkOutput("t4_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t4_drain_seq_%0d", i), 64'(m_seq), 64'(exp4[i]));
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t4_empty_level", 64'(level), 64'd0);
    checkOutput("t4_empty_valid", 64'(m_valid), 64'd0);
    checkOutput("t4_empty_md", 64'(|m_metadata), 64'd0);

    // 5: 4-bit sequence wraps after 15; 2-bit drop counter saturates at 3.
    $display("[TB] step 5: wrap and saturation");
    doReset();
    for (int i = 0; i < 17; i++) begin
      runFrame(1'b1);
      checkOutput($sformatf("t5_seq_%0d", i), 64'(m_seq), 64'(i % 16));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_drained", 64'(level), 64'd0);
    for (int j = 0; j < 13; j++) begin
      runFrame(1'b0);
      if (j >= 8) begin
        checkOutput($sformatf("t5_drop_%0d", j), 64'(drop_cnt),
                    64'(((j - 7) > 3) ? 3 : (j - 7)));
      end
    end
    checkOutput("t5_level_full", 64'(level), 64'd8);

    // 6: reset asserted mid-frame with three entries queued.
    $display("[TB] step 6: reset mid-frame");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("t6_level_3", 64'(level), 64'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(m_valid), 64'd0);
    checkOutput("t6_rst_level", 64'(level), 64'd0);
    checkOutput("t6_rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t6_no_capture_level", 64'(level), 64'd0);
    checkOutput("t6_no_capture_valid", 64'(m_valid), 64'd0);
    runFrame(1'b0);
    checkOutput("t6_new_frame_seq", 64'(m_seq), 64'd0);
    checkOutput("t6_new_frame_level", 64'(level), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
